lcd_capture: RTL and testbench

Downstream consumer of the video unit's LCD pixel stream (`lcd_clkena`, `lcd_data`, `lcd_mode`, `lcd_on`). Tracks x/y position, writes each 2-bit pixel into a double-buffered 160x144 framebuffer, and swaps banks at every complete vblank. When the LCD is switched off, it clears the displayed bank to colour 0. This gives the scaler/video-out stage a stable, tear-free frame.

---
 rtl/lcd_capture.sv | 160 ++++++++++++++++
 tb/tb_lcd_capture.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture.sv
// Captures the LCD pixel stream into a double-buffered framebuffer.
// Banks swap only after a complete, well-formed frame; LCD-off clears the shown bank.
module lcd_capture #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lcd_clkena,
  input  logic [1:0]  lcd_data,
  input  logic [1:0]  lcd_mode,
  input  logic        lcd_on,
  output logic        fb_wr,
  output logic        fb_bank,
  output logic [14:0] fb_addr,
  output logic [1:0]  fb_data,
  output logic        disp_bank,
  output logic        frame_done,
  output logic        frame_err
);
  localparam logic [7:0]  W8   = 8'(WIDTH);
  localparam logic [7:0]  H8   = 8'(HEIGHT);
  localparam logic [14:0] W15  = 15'(WIDTH);
  localparam logic [14:0] LAST = 15'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {SYNC, ACTIVE, FILL} state_t;

  state_t      state, state_n;
  logic [7:0]  x, x_n, y, y_n;
  logic [14:0] base, base_n, fill_cnt, fill_n;
  logic        err_latch, errl_n;
  logic [1:0]  mode_d;
  logic        on_d;
  logic        wr_n, bank_n, disp_n, done_n, ferr_n;
  logic [14:0] addr_n;
  logic [1:0]  data_n;

  logic line_end, vbl_start, off, pix;
  assign line_end  = (mode_d == 2'd3) && (lcd_mode != 2'd3);
  assign vbl_start = (mode_d != 2'd1) && (lcd_mode == 2'd1);
  assign off       = on_d && !lcd_on;
  // A strobe in the LINE_END cycle still belongs to the line being closed.
  assign pix       = lcd_clkena && ((lcd_mode == 2'd3) || line_end);

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    base_n  = base;
    fill_n  = fill_cnt;
    errl_n  = err_latch;
    disp_n  = disp_bank;
    wr_n    = 1'b0;
    bank_n  = fb_bank;
    addr_n  = fb_addr;
    data_n  = fb_data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      SYNC: begin
        if (off) begin
          state_n = FILL;
          fill_n  = '0;
        end else if (vbl_start && lcd_on) begin
          state_n = ACTIVE;
          x_n     = '0;
          y_n     = '0;
          base_n  = '0;
          errl_n  = 1'b0;
        end
      end
      ACTIVE: begin
        if (off) begin
          state_n = FILL;
          fill_n  = '0;
        end else begin
          if (pix) begin
            if (x < W8 && y < H8) begin
              wr_n   = 1'b1;
              bank_n = ~disp_bank;
              addr_n = base + {7'b0, x};
              data_n = lcd_data;
            end else begin
              errl_n = 1'b1;
            end
            if (x < W8) x_n = x + 8'd1;
          end
          // Line/vblank checks see the effect of this cycle's strobe.
          if (line_end) begin
            if (x_n != W8) errl_n = 1'b1;
            x_n = '0;
            if (y < H8) begin
              y_n    = y + 8'd1;
              base_n = base + W15;
            end else begin
              errl_n = 1'b1;
            end
          end
          if (vbl_start) begin
            if (y_n == H8 && !errl_n) begin
              disp_n = ~disp_bank;
              done_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
            x_n    = '0;
            y_n    = '0;
            base_n = '0;
            errl_n = 1'b0;
          end
        end
      end
      FILL: begin
        wr_n   = 1'b1;
        bank_n = disp_bank;
        addr_n = fill_cnt;
        data_n = 2'd0;
        if (fill_cnt == LAST) state_n = SYNC;
        else                  fill_n  = fill_cnt + 15'd1;
      end
      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SYNC;
      x          <= '0;
      y          <= '0;
      base       <= '0;
      fill_cnt   <= '0;
      err_latch  <= 1'b0;
      mode_d     <= 2'd1;
      on_d       <= 1'b0;
      disp_bank  <= 1'b1;
      fb_wr      <= 1'b0;
      fb_bank    <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      base       <= base_n;
      fill_cnt   <= fill_n;
      err_latch  <= errl_n;
      mode_d     <= lcd_mode;
      on_d       <= lcd_on;
      disp_bank  <= disp_n;
      fb_wr      <= wr_n;
      fb_bank    <= bank_n;
      fb_addr    <= addr_n;
      fb_data    <= data_n;
      frame_done <= done_n;
      frame_err  <= ferr_n;
    end
  end
endmodule

// File: tb/tb_lcd_capture.sv
// Randomized bench for lcd_capture: a frame/line-level model predicts every write
// (cycle, bank, address, data) and every swap/error pulse.
module tb_lcd_capture;
  localparam int W = 160;
  localparam int H = 144;
  localparam int NPIX = W * H;

  logic        clk, reset_n;
  logic        lcd_clkena, lcd_on;
  logic [1:0]  lcd_data, lcd_mode;
  logic        fb_wr, fb_bank, disp_bank, frame_done, frame_err;
  logic [14:0] fb_addr;
  logic [1:0]  fb_data;

  lcd_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n), .lcd_clkena(lcd_clkena), .lcd_data(lcd_data),
    .lcd_mode(lcd_mode), .lcd_on(lcd_on), .fb_wr(fb_wr), .fb_bank(fb_bank),
    .fb_addr(fb_addr), .fb_data(fb_data), .disp_bank(disp_bank),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input int c, input logic b, input int a, input logic [1:0] d);
    return {14'b0, c[31:0], b, a[14:0], d};
  endfunction

  // Monitor: collects observed writes and pulses away from the active edge.
  logic [63:0] act_q[$];
  logic [63:0] exp_q[$];
  int done_cnt = 0, err_cnt = 0, last_done_cyc = -1, last_err_cyc = -1;
  int run = 0, last_run = 0;
  logic [1:0] d23039 = 2'd0;

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (fb_wr) begin
        act_q.push_back(pk(cyc, fb_bank, int'(fb_addr), fb_data));
        if (fb_addr == 15'd23039) d23039 = fb_data;
        run++;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end
      if (frame_done) begin done_cnt++; last_done_cyc = cyc; end
      if (frame_err)  begin err_cnt++;  last_err_cyc  = cyc; end
    end
  end

  // Reference model: line index, frame health, and the bank on display.
  int   ml  = 0;
  bit   bad = 0;
  logic exp_disp = 1'b1;

  task automatic drive(input logic on, input logic [1:0] m, input logic e, input logic [1:0] d);
    lcd_on = on; lcd_mode = m; lcd_clkena = e; lcd_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_px(input int i, input logic [1:0] d);
    if (i < W && ml < H) exp_q.push_back(pk(cyc + 1, ~exp_disp, ml * W + i, d));
    else bad = 1;
  endtask

  task automatic exp_line_end(input int n);
    if (n != W) bad = 1;
    if (ml < H) ml++;
    else bad = 1;
  endtask

  task automatic line(input int n, input bit simul, input bit ramp, input bit gaps);
    int k = 0;
    int n3 = simul ? n - 1 : n;
    logic e;
    logic [1:0] d;
    while (k < n3) begin
      e = gaps ? ($urandom_range(0, 15) != 0) : 1'b1;
      d = ramp ? 2'(k) : 2'($urandom_range(0, 3));
      if (e) begin exp_px(k, d); k++; end
      drive(1'b1, 2'd3, e, d);
    end
    if (simul) begin
      d = ramp ? 2'(n - 1) : 2'($urandom_range(0, 3));
      exp_px(n - 1, d);
      drive(1'b1, 2'd0, 1'b1, d);
    end else begin
      drive(1'b1, 2'd0, 1'b0, 2'($urandom_range(0, 3)));
    end
    exp_line_end(n);
    // Strobes outside mode 3 must be ignored.
    drive(1'b1, 2'd2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
  endtask

  task automatic vblank(input string tag, input bit from_sync);
    int c0 = cyc + 1;
    int d0 = done_cnt, e0 = err_cnt;
    int xd = 0, xe = 0;
    if (!from_sync) begin
      if (ml == H && !bad) begin xd = 1; exp_disp = ~exp_disp; end
      else xe = 1;
    end
    ml = 0; bad = 0;
    repeat (3) drive(1'b1, 2'd1, 1'b0, 2'd0);
    drive(1'b1, 2'd2, 1'b0, 2'd0);
    chk({tag, "_done_n"}, done_cnt - d0, xd);
    chk({tag, "_err_n"}, err_cnt - e0, xe);
    if (xd == 1) chk({tag, "_done_cyc"}, last_done_cyc, c0);
    if (xe == 1) chk({tag, "_err_cyc"}, last_err_cyc, c0);
    chk({tag, "_disp"}, disp_bank, exp_disp);
  endtask

  task automatic drain(input string tag);
    int n;
    chk({tag, "_nwr"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int c;
    reset_n = 1'b0;
    lcd_on = 1'b1; lcd_mode = 2'd0; lcd_clkena = 1'b0; lcd_data = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", fb_wr, 0);
    chk("rst_bank", fb_bank, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_disp", disp_bank, 1);
    chk("rst_done", frame_done, 0);
    chk("rst_ferr", frame_err, 0);
    reset_n = 1'b1;
    repeat (2) drive(1'b1, 2'd0, 1'b0, 2'd0);
    // Sync, then a partial frame cut by LCD-off on line 70.
    vblank("sync0", 1'b1);
    for (int l = 0; l < 70; l++) line(W, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      logic [1:0] d = 2'($urandom_range(0, 3));
      exp_px(k, d);
      drive(1'b1, 2'd3, 1'b1, d);
    end
    c = cyc;
    for (int k = 0; k < NPIX; k++) exp_q.push_back(pk(c + 2 + k, exp_disp, k, 2'd0));
    drive(1'b0, 2'd3, 1'b1, 2'd3);
    for (int j = 0; j < NPIX + 4; j++) begin
      if (j < 8000)
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      else
        drive(1'b1, 2'd0, 1'b0, 2'd0);
    end
    chk("fill_run", last_run, NPIX);
    drain("fill");
    // First vblank after the fill only resynchronises.
    vblank("postfill", 1'b1);
    // Clean ramp frame into bank 0.
    for (int l = 0; l < H; l++) line(W, 1'b0, 1'b1, 1'b0);
    vblank("f0", 1'b0);
    chk("f0_a23039", d23039, 3);
    drain("f0");
    // Malformed frame: overlong line 0, strobe on LINE_END for line 5, short line 10.
    for (int l = 0; l < 12; l++) begin
      if (l == 0)       line(W + 1, 1'b0, 1'b0, 1'b1);
      else if (l == 5)  line(W, 1'b1, 1'b0, 1'b1);
      else if (l == 10) line(W - 1, 1'b0, 1'b0, 1'b1);
      else              line(W, 1'b0, 1'b0, 1'b1);
    end
    vblank("f1", 1'b0);
    drain("f1");
    // Next clean frame swaps normally.
    for (int l = 0; l < H; l++) line(W, 1'b0, 1'b0, 1'b0);
    vblank("f2", 1'b0);
    drain("f2");
    // LCD off, then async reset part-way through the fill.
    repeat (2) drive(1'b1, 2'd0, 1'b0, 2'd0);
    repeat (300) drive(1'b0, 2'd0, 1'b0, 2'd0);
    chk("fill2_wr", fb_wr, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_wr", fb_wr, 0);
    chk("arst_disp", disp_bank, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    act_q.delete();
    repeat (4) drive(1'b1, 2'd0, 1'b0, 2'd0);
    chk("post_rst_nwr", act_q.size(), 0);
    chk("post_rst_disp", disp_bank, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
